execute_sequencer: RTL

Controller in front of the execute stage. It accepts one decoded instruction at a time from decode over a valid/ready handshake and drives the execute unit's enable. It waits a class-dependent number of cycles (single-cycle ALU, ECALL, multi-cycle MUL/DIV), latches the result and branch outcome, and presents them to memory stage over valid/ready. On a taken jump it issues a one-cycle redirect/flush and drops wrong-path input in that cycle.

---
 rtl/exec_seq_pkg.sv | 42 ++++
 rtl/execute_sequencer_wait_counter.sv | 49 ++++
 rtl/execute_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_seq_pkg
// Description : Shared types and constants for the execute sequencer.
//               - state encoding of the sequencer FSM
//               - execute class encoding driven by decode on in_class
//               - ECALL opcode / instruction constants used by decode when
//                 it forms in_class
// Revision    : 1.0 - initial release
// ============================================================================
package exec_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_ECALL  = 2'd1,
    CLS_MULDIV = 2'd2,
    CLS_RSVD   = 2'd3
  } exec_class_t;

  // RISC-V SYSTEM major opcode and the full ECALL encoding.
  localparam logic [6:0]  c_OPC_SYSTEM = 7'b111_0011;
  localparam logic [31:0] c_INSN_ECALL = 32'h0000_0073;

  // Reserved class code runs as a single-cycle ALU operation.
  function automatic exec_class_t norm_class(input logic [1:0] raw);
    return (raw == 2'd3) ? CLS_ALU : exec_class_t'(raw);
  endfunction

  // Decode-side helper: recognise ECALL from a raw 32-bit instruction.
  function automatic logic is_ecall(input logic [31:0] insn);
    return (insn[6:0] == c_OPC_SYSTEM) && (insn == c_INSN_ECALL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_sequencer_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_wait_counter
// Description : Loadable up-counter used while the sequencer sits in WAIT.
//               Flags when the count equals the multi-cycle terminal value
//               and when it equals the ECALL timeout value.
// Ports       : clk, reset      - clock, async active-high reset
//               i_clear         - force count to zero (new instruction)
//               i_load          - load i_load_value
//               i_load_value    - value to load
//               i_inc           - increment by one
//               o_at_term       - count == TERM
//               o_at_timeout    - count == TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module seq_wait_counter #(
  parameter int WIDTH   = 8,
  parameter int TERM    = 7,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_inc,
  output logic             o_at_term,
  output logic             o_at_timeout
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_at_term    = (r_count == WIDTH'(TERM));
  assign o_at_timeout = (r_count == WIDTH'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/execute_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : execute_sequencer
// Description : Controller in front of the execute stage. Accepts one decoded
//               instruction at a time, enables the execute unit for a
//               class-dependent number of cycles, latches the result and
//               branch outcome and offers them to the memory stage. A taken
//               jump raises a one-cycle redirect/flush pulse, during which
//               new input is refused.
// Ports       : clk, reset                 - clock, async active-high reset
//               in_valid/in_ready          - decode handshake
//               in_pc, in_class            - incoming instruction
//               exec_enable, exec_done     - execute unit control/completion
//               alu_result, jump_taken,
//               jump_target                - execute results (sampled at
//                                            completion)
//               out_valid/out_ready        - memory-stage handshake
//               out_pc, out_result,
//               out_jump                   - latched results
//               redirect_valid/redirect_pc - fetch redirect pulse
//               ecall_timeout              - sticky ECALL timeout flag
//               busy_cycles                - cycles spent in EXEC/WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module execute_sequencer
  import exec_seq_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int MULDIV_CYCLES = 8,
  parameter int ECALL_TIMEOUT = 255,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [1:0]       in_class,
  output logic             exec_enable,
  input  logic             exec_done,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             jump_taken,
  input  logic [XLEN-1:0]  jump_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_result,
  output logic             out_jump,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             ecall_timeout,
  output logic [CNT_W-1:0] busy_cycles
);

  localparam int c_WAIT_MAX = (ECALL_TIMEOUT > MULDIV_CYCLES) ? ECALL_TIMEOUT : MULDIV_CYCLES;
  localparam int c_WAIT_W   = $clog2(c_WAIT_MAX + 1);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  exec_class_t      r_cls;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_out_pc;
  logic [XLEN-1:0]  r_out_result;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_out_jump;
  logic             r_first_hold;
  logic             r_ecall_timeout;
  logic [CNT_W-1:0] r_busy;

  logic w_in_ready;
  logic w_redirect;
  logic w_accept;
  logic w_done_normal;
  logic w_force_tmo;
  logic w_complete;
  logic w_cnt_term;
  logic w_cnt_tmo;

  // The counter holds the number of execute cycles already spent: EXEC
  // loads 1, each WAIT cycle adds one.
  seq_wait_counter #(
    .WIDTH   (c_WAIT_W),
    .TERM    (MULDIV_CYCLES - 1),
    .TIMEOUT (ECALL_TIMEOUT)
  ) u_wait_counter (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_accept),
    .i_load       (r_state == ST_EXEC),
    .i_load_value (c_WAIT_W'(1)),
    .i_inc        (r_state == ST_WAIT),
    .o_at_term    (w_cnt_term),
    .o_at_timeout (w_cnt_tmo)
  );

  assign w_accept = in_valid & w_in_ready;

  // Completion decode. exec_done only matters for ECALL; a done that lands
  // on the timeout cycle still counts as a normal completion.
  always_comb begin
    w_done_normal = 1'b0;
    w_force_tmo   = 1'b0;
    case (r_state)
      ST_EXEC: begin
        case (r_cls)
          CLS_ECALL:  w_done_normal = exec_done;
          CLS_MULDIV: w_done_normal = 1'b0;
          default:    w_done_normal = 1'b1;
        endcase
      end
      ST_WAIT: begin
        case (r_cls)
          CLS_ECALL: begin
            w_done_normal = exec_done;
            w_force_tmo   = ~exec_done & w_cnt_tmo;
          end
          CLS_MULDIV: w_done_normal = w_cnt_term;
          default:    w_done_normal = 1'b1;
        endcase
      end
      default: begin
        w_done_normal = 1'b0;
        w_force_tmo   = 1'b0;
      end
    endcase
  end

  assign w_complete = w_done_normal | w_force_tmo;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = w_complete ? ST_HOLD : ST_WAIT;
      ST_WAIT: if (w_complete) w_next_state = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          w_next_state = w_accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode. The redirect pulse lives only in the first HOLD cycle
  // and blocks acceptance so the wrong-path instruction is dropped.
  always_comb begin
    exec_enable = 1'b0;
    out_valid   = 1'b0;
    w_redirect  = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_EXEC,
      ST_WAIT: exec_enable = 1'b1;
      ST_HOLD: begin
        out_valid  = 1'b1;
        w_redirect = r_first_hold & r_out_jump;
        w_in_ready = out_ready & ~(r_first_hold & r_out_jump);
      end
      default: begin
        exec_enable = 1'b0;
        out_valid   = 1'b0;
      end
    endcase
  end

  // Instruction, result and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc            <= '0;
      r_cls           <= CLS_ALU;
      r_out_pc        <= '0;
      r_out_result    <= '0;
      r_out_jump      <= 1'b0;
      r_redirect_pc   <= '0;
      r_first_hold    <= 1'b0;
      r_ecall_timeout <= 1'b0;
      r_busy          <= '0;
    end else begin
      if (w_accept) begin
        r_pc  <= in_pc;
        r_cls <= norm_class(in_class);
      end
      if (w_complete) begin
        r_out_pc      <= r_pc;
        r_out_result  <= w_force_tmo ? '0 : alu_result;
        r_out_jump    <= ~w_force_tmo & jump_taken;
        r_redirect_pc <= w_force_tmo ? '0 : jump_target;
        r_first_hold  <= 1'b1;
      end else if (r_state == ST_HOLD) begin
        r_first_hold  <= 1'b0;
      end
      if (w_force_tmo) begin
        r_ecall_timeout <= 1'b1;
      end
      if (exec_enable) begin
        r_busy <= r_busy + CNT_W'(1);
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign redirect_valid = w_redirect;
  assign out_pc         = r_out_pc;
  assign out_result     = r_out_result;
  assign out_jump       = r_out_jump;
  assign redirect_pc    = r_redirect_pc;
  assign ecall_timeout  = r_ecall_timeout;
  assign busy_cycles    = r_busy;

endmodule
`default_nettype wire
